riscv_rf_scoreboard: RTL

- Sits between the ID stage and write port B of the register file.
- Tracks registers with a pending long-latency write (loads, multicycle mult/div) and stalls ID on RAW/WAW hazards against them.
- Merges LSU and MULT completions onto the single write port B through a one-entry skid buffer.
- Port A (single-cycle ALU writeback) does not pass through this block.

---
 rtl/riscv_rf_scoreboard.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/riscv_rf_scoreboard.sv
// ============================================================================
// Module   : riscv_rf_scoreboard
// Purpose  : Long-latency write scoreboard and LSU/MULT merge onto RF port B.
//            Optional macro RF_SB_BYPASS_EN adds port-B forwarding to ID.
// Revision : 1.0
// ============================================================================
`default_nettype none

module riscv_rf_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic [ADDR_WIDTH-1:0] id_raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] id_raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] id_raddr_c_i,
  input  logic                  id_use_a_i,
  input  logic                  id_use_b_i,
  input  logic                  id_use_c_i,
  input  logic [ADDR_WIDTH-1:0] id_rd_i,
  input  logic                  id_we_i,
  input  logic                  id_long_i,
  output logic                  stall_o,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
  input  logic                  mul_valid_i,
  output logic                  mul_ready_o,
  input  logic [ADDR_WIDTH-1:0] mul_rd_i,
  input  logic [DATA_WIDTH-1:0] mul_wdata_i,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o
`ifdef RF_SB_BYPASS_EN
  ,
  output logic                  fwd_a_o,
  output logic                  fwd_b_o,
  output logic                  fwd_c_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o
`endif
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0]   r_pending;
  logic [NUM_REGS-1:0]   w_pending_nxt;
  logic                  r_skid_valid;
  logic [ADDR_WIDTH-1:0] r_skid_rd;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_we_b;
  logic [ADDR_WIDTH-1:0] r_waddr_b;
  logic [DATA_WIDTH-1:0] r_wdata_b;

  logic w_byp_a, w_byp_b, w_byp_c;
  logic w_hz_a, w_hz_b, w_hz_c, w_hz_w;
  logic w_stall, w_issue, w_mul_accept;

`ifdef RF_SB_BYPASS_EN
  // A source being written on port B this cycle is read through the bypass.
  assign w_byp_a = r_we_b && (r_waddr_b == id_raddr_a_i);
  assign w_byp_b = r_we_b && (r_waddr_b == id_raddr_b_i);
  assign w_byp_c = r_we_b && (r_waddr_b == id_raddr_c_i);

  assign fwd_a_o    = id_use_a_i && r_we_b && (r_waddr_b == id_raddr_a_i) && (r_waddr_b != '0);
  assign fwd_b_o    = id_use_b_i && r_we_b && (r_waddr_b == id_raddr_b_i) && (r_waddr_b != '0);
  assign fwd_c_o    = id_use_c_i && r_we_b && (r_waddr_b == id_raddr_c_i) && (r_waddr_b != '0);
  assign fwd_data_o = r_wdata_b;
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
  assign w_byp_c = 1'b0;
`endif

  assign w_hz_a  = id_use_a_i && r_pending[id_raddr_a_i] && !w_byp_a;
  assign w_hz_b  = id_use_b_i && r_pending[id_raddr_b_i] && !w_byp_b;
  assign w_hz_c  = id_use_c_i && r_pending[id_raddr_c_i] && !w_byp_c;
  assign w_hz_w  = id_we_i && r_pending[id_rd_i];
  assign w_stall = id_valid_i && (w_hz_a || w_hz_b || w_hz_c || w_hz_w);

  assign w_issue      = id_valid_i && !w_stall && id_we_i && id_long_i && (id_rd_i != '0);
  assign w_mul_accept = mul_valid_i && !r_skid_valid;

  // Clear from the port-B write first so a same-cycle issue wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_we_b) w_pending_nxt[r_waddr_b] = 1'b0;
    if (w_issue) w_pending_nxt[id_rd_i] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_skid_rd    <= '0;
      r_skid_data  <= '0;
      r_we_b       <= 1'b0;
      r_waddr_b    <= '0;
      r_wdata_b    <= '0;
    end else if (lsu_valid_i) begin
      r_we_b    <= (lsu_rd_i != '0);
      r_waddr_b <= lsu_rd_i;
      r_wdata_b <= lsu_rdata_i;
      if (w_mul_accept) begin
        r_skid_valid <= 1'b1;
        r_skid_rd    <= mul_rd_i;
        r_skid_data  <= mul_wdata_i;
      end
    end else if (r_skid_valid) begin
      r_we_b       <= (r_skid_rd != '0);
      r_waddr_b    <= r_skid_rd;
      r_wdata_b    <= r_skid_data;
      r_skid_valid <= 1'b0;
    end else if (w_mul_accept) begin
      r_we_b    <= (mul_rd_i != '0);
      r_waddr_b <= mul_rd_i;
      r_wdata_b <= mul_wdata_i;
    end else begin
      r_we_b <= 1'b0;
    end
  end

  assign stall_o     = w_stall;
  assign mul_ready_o = !r_skid_valid;
  assign we_b_o      = r_we_b;
  assign waddr_b_o   = r_waddr_b;
  assign wdata_b_o   = r_wdata_b;

endmodule

`default_nettype wire
